tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Round-robin scheduler that shares the single `uart_tx` instance among several byte-stream requesters, such as the command-response FIFO and asynchronous event/status reporters. It grants one requester at a time and paces bytes into the transmitter using its `tx_data_ready`/`tx_done` handshake. A grant is locked for a whole packet, so multi-byte replies such as enable masks and pin maps are never interleaved on the serial line.

## Interface
- `N_REQ`, default 4: number of requesters (1–8).
- `WD_CYCLES`, default 255: watchdog stall limit in clocks; used only with `TX_ARB_WATCHDOG_EN`.
- `clk`  in  1  system clock; everything is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has a byte on `req_data[8i+:8]`.
- `req_data`  in  8*N_REQ  packed request bytes.
- `req_last`  in  N_REQ  the byte offered by requester i ends its packet.
- `req_ready`  out  N_REQ  one-hot accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_ready`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_done`  in  1  high while `uart_tx` is idle.
- `grant`  out  N_REQ  one-hot current packet owner; zero when unlocked.
- `busy`  out  1  high in any state other than S_IDLE.
- `stall_err`  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- States:
  - S_IDLE: may accept a byte.
  - S_START: start pulse issued.
  - S_BUSY: waiting for the transmitter to finish.
- Winner selection happens in S_IDLE with `tx_done`=1.
  - If `grant`≠0, only the owner is eligible.
  - Otherwise, the first valid requester scanning from `ptr`, `ptr`+1, … mod N_REQ.
- `req_ready` is combinational: one-hot of the winner, only in S_IDLE with `tx_done`=1 and a valid winner.
- On transfer:
  - Register `tx_data` <= winner byte and `tx_data_ready` <= 1.
  - Go to S_START.
  - If `req_last`: set `grant` <= 0 and `ptr` <= winner+1 (wraps N_REQ-1→0).
  - Otherwise: set `grant` <= onehot(winner).
- S_START:
  - `tx_data_ready` <= 0 (pulse is exactly 1 cycle).
  - Move to S_BUSY when `tx_done`=0 is sampled. The pulse is not re-issued while waiting.
- S_BUSY: return to S_IDLE when `tx_done`=1.
- A single-byte packet (`req_last` on its first byte) never asserts `grant`.
- While locked, other requesters are stalled regardless of their `req_valid`.
- If the owner drops `req_valid` mid-packet, the lock is held indefinitely (unless the watchdog is enabled).
- Reset values: `tx_data`=8'hFF, `tx_data_ready`=0, `grant`=0, `busy`=0, `stall_err`=0, `ptr`=0, state S_IDLE.
- Reset mid-packet discards the lock and the in-flight start. The bytes already handed to `uart_tx` are not recalled.
- Reset dominates all other events in the same cycle.
- N_REQ=1: round-robin degenerates to a fixed grant; locking still applies.

## Timing
- Accept at edge T (`req_ready` high in cycle T). `tx_data` and `tx_data_ready` are valid in cycle T+1.
- `tx_data` stays stable until the next accept.
- Minimum spacing between accepts: 3 cycles plus the `uart_tx` frame time. The next `req_ready` comes no earlier than the first S_IDLE cycle with `tx_done`=1.
- Round-robin fairness: with all requesters continuously valid, single-byte packets are served 0,1,2,3,0,…
- `req_last` is sampled only on the transfer cycle.

## Configuration
- `TX_ARB_WATCHDOG_EN` defined:
  - A counter runs while `grant`≠0, in S_IDLE, `tx_done`=1 and the owner's `req_valid`=0.
  - The counter clears on any owner transfer.
  - On reaching `WD_CYCLES`: `grant` <= 0, `ptr` <= owner+1, `stall_err` <= 1. `stall_err` is sticky until reset.
- Not defined: no counter; the lock is held until `req_last`; `stall_err` is constant 0.

## Test plan
- After reset, check outputs: `tx_data`=FF, `tx_data_ready`=0, `grant`=0, `busy`=0.
- Req0 sends single byte 0xA5 with `last`=1, transmitter model idle. Expect:
  - `req_ready[0]` in cycle T.
  - `tx_data`=A5 and a 1-cycle `tx_data_ready` at T+1.
  - No second accept until `tx_done` has fallen and risen again.
- Req1 sends a 2-byte packet 0x01,0x80 while req2 holds valid with 0x55. Expect line order 01, 80, 55, and `grant`=0010 between the two req1 bytes.
- All four requesters continuously valid with single-byte packets 0x10–0x13. Expect 8 transmissions in order 10,11,12,13,10,11,12,13.
- Reset asserted while in S_BUSY mid-packet of req3. Expect `grant`=0 and S_IDLE on the next cycle; `ptr`=0 so req0 is served first afterwards.
- Watchdog (macro on, `WD_CYCLES`=8): req2 sends a non-last byte, then drops `valid`; req0 is valid. Expect `stall_err`=1 and `grant`=0 after 8 stalled idle cycles, then req0 is served before req2 (`ptr`=3 scan order 3,0,…).

Source files
------------

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Round-robin scheduler sharing one uart_tx among N_REQ byte-stream
// requesters. One byte is in flight at a time, paced by the transmitter's
// tx_data_ready / tx_done handshake. A requester that sends a byte without
// req_last locks the grant until its packet ends, so multi-byte replies are
// never interleaved on the serial line.
//
// Parameters
//   N_REQ      number of requesters (1..8)
//   WD_CYCLES  stall limit in clocks for the lock watchdog
//
// Optional feature
//   TX_ARB_WATCHDOG_EN  when defined, a lock whose owner stops offering bytes
//                       is released after WD_CYCLES stalled idle cycles and
//                       stall_err is set (sticky). When undefined, the lock is
//                       held until req_last and stall_err is constant 0.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   req_valid      per-requester byte valid
//   req_data       packed request bytes, requester i on [8i+:8]
//   req_last       per-requester end-of-packet marker for the offered byte
//   req_ready      one-hot accept strobe (combinational)
//   tx_data        byte presented to uart_tx
//   tx_data_ready  one-cycle start pulse to uart_tx
//   tx_done        high while uart_tx is idle
//   grant          one-hot owner of a locked packet, zero when unlocked
//   busy           high whenever a byte is being started or transmitted
//   stall_err      sticky watchdog flag
// -----------------------------------------------------------------------------
module tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WD_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_data_ready,
    input  logic               tx_done,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               stall_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 1 || N_REQ > 8 || WD_CYCLES < 1) begin : g_bad_cfg
        $error("tx_arbiter: N_REQ must be 1..8 and WD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;       // first requester to consider when unlocked
    logic [PTR_W-1:0] owner;     // index of the locked requester, valid while grant != 0
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             win_found;
    logic             accept;
    logic [7:0]       win_byte;
    logic             wd_fire;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    // Winner selection. While locked only the owner may win; otherwise the
    // scan runs downward so the last hit is the one closest to ptr.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        if (grant != '0) begin
            win_idx   = owner;
            win_found = req_valid[owner];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                scan_idx = PTR_W'((int'(ptr) + k) % N_REQ);
                if (req_valid[scan_idx]) begin
                    win_idx   = scan_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    assign accept   = (state == S_IDLE) && tx_done && win_found;
    assign win_byte = req_data[int'(win_idx)*8 +: 8];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state         <= S_IDLE;
            tx_data       <= 8'hFF;
            tx_data_ready <= 1'b0;
            grant         <= '0;
            owner         <= '0;
            ptr           <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tx_data       <= win_byte;
                        tx_data_ready <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_START;
                        if (req_last[win_idx]) begin
                            grant <= '0;
                            ptr   <= next_idx(win_idx);
                        end else begin
                            grant <= req_ready;
                            owner <= win_idx;
                        end
                    end else if (wd_fire) begin
                        // Abandoned lock: release it and move past the owner.
                        grant <= '0;
                        ptr   <= next_idx(owner);
                    end
                end
                S_START: begin
                    // Pulse lasts one cycle; wait for uart_tx to go busy
                    // without re-issuing the start.
                    tx_data_ready <= 1'b0;
                    if (!tx_done) begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (tx_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_stall;
    logic            stall_q;

    // A stalled cycle: locked, ready to accept, but the owner offers nothing.
    assign wd_stall = (grant != '0) && (state == S_IDLE) && tx_done && !req_valid[owner];
    assign wd_fire  = wd_stall && (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            stall_q <= 1'b0;
        end else if (wd_fire) begin
            wd_cnt  <= '0;
            stall_q <= 1'b1;
        end else if (wd_stall) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else if (accept) begin
            wd_cnt <= '0;
        end
    end

    assign stall_err = stall_q;
`else
    assign wd_fire   = 1'b0;
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//
// Drives tx_arbiter from per-requester packet queues, emulates uart_tx with a
// random start latency and frame length, and compares the serial byte order
// with a packet-level round-robin model. Directed scenarios follow the
// single-byte, locked two-byte, fairness, reset-mid-packet and (when
// TX_ARB_WATCHDOG_EN is defined) watchdog cases; random rounds follow.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

    localparam int N = 4;
`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 255;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_data_ready;
    logic           tx_done;
    logic [N-1:0]   grant;
    logic           busy;
    logic           stall_err;

    tx_arbiter #(.N_REQ(N), .WD_CYCLES(WD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .tx_done       (tx_done),
        .grant         (grant),
        .busy          (busy),
        .stall_err     (stall_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester traffic still to be offered.
    logic [7:0] byte_q [N][$];
    bit         last_q [N][$];
    bit         mid    [N];

    // Expected serial order and what was actually started.
    logic [7:0] exp_q    [$];
    logic [7:0] line_log [$];

    logic [N-1:0] exp_grant   = '0;
    logic [7:0]   exp_tx_data = 8'hFF;
    bit rst_req   = 1'b1;
    bit rst_prev  = 1'b0;
    bit chk_en    = 1'b0;
    bit grant_chk = 1'b1;
    bit acc_prev  = 1'b0;
    bit prev_tdr  = 1'b0;
    bit done_fell = 1'b1;
    int u_lat     = -1;
    int u_frame   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet-level round robin: starting at p, the first requester with
    // pending traffic sends its whole packet, then p moves past it.
    function automatic void predict(input int p);
        logic [7:0] bq [N][$];
        bit         lq [N][$];
        for (int i = 0; i < N; i++) begin
            bq[i] = byte_q[i];
            lq[i] = last_q[i];
        end
        for (int guard = 0; guard < 1000; guard++) begin
            int w;
            bit l;
            w = -1;
            for (int k = 0; k < N && w < 0; k++) begin
                if (bq[(p + k) % N].size() != 0) w = (p + k) % N;
            end
            if (w < 0) return;
            l = 1'b0;
            while (bq[w].size() != 0 && !l) begin
                exp_q.push_back(bq[w].pop_front());
                l = lq[w].pop_front();
            end
            if (!l) return;  // open packet: the owner keeps the line
            p = (w + 1) % N;
        end
    endfunction

    function automatic bit uart_idle();
        return tx_done && (u_lat < 0) && (u_frame == 0);
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        logic [N-1:0] oh;
        bit gap;
        @(negedge clk);
        rst_n = !rst_req;
        if (u_lat > 0) begin
            u_lat--;
        end else if (u_lat == 0) begin
            tx_done = 1'b0;
            u_frame = $urandom_range(1, 6);
            u_lat   = -1;
        end else if (u_frame > 0) begin
            u_frame--;
            if (u_frame == 0) tx_done = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            gap = mid[i] && ($urandom_range(0, 3) == 0);
            req_valid[i] = !rst_req && (byte_q[i].size() != 0) && !gap;
            req_data[8*i +: 8] = (byte_q[i].size() != 0) ? byte_q[i][0] : 8'($urandom);
            req_last[i] = (last_q[i].size() != 0) ? last_q[i][0] : 1'($urandom);
        end
        #1;
        if (chk_en) begin
            if (rst_prev) begin
                check("rst_busy", busy, 0);
                check("rst_tx_data_ready", tx_data_ready, 0);
                check("rst_stall_err", stall_err, 0);
            end else if (prev_tdr) begin
                check("start_pulse_one_cycle", tx_data_ready, 0);
            end
            if (acc_prev) begin
                check("start_after_accept", tx_data_ready, 1);
                check("busy_after_accept", busy, 1);
            end
            check("tx_data", tx_data, exp_tx_data);
            if (grant_chk) check("grant", grant, exp_grant);
            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("ready_only_valid", req_ready & ~req_valid, 0);
                check("ready_tx_idle", tx_done, 1);
                check("ready_after_tx_cycle", done_fell, 1);
                done_fell = 1'b0;
            end
            if (tx_data_ready) begin
                line_log.push_back(tx_data);
                if (exp_q.size() == 0) check("line_byte_expected", 0, 1);
                else check("line_byte", tx_data, exp_q.pop_front());
                u_lat = $urandom_range(0, 2);
            end
        end
        if (!tx_done) done_fell = 1'b1;
        acc_prev = 1'b0;
        if (rst_req) begin
            exp_grant   = '0;
            exp_tx_data = 8'hFF;
            done_fell   = 1'b1;
            for (int i = 0; i < N; i++) mid[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_prev    = 1'b1;
                    exp_tx_data = byte_q[i][0];
                    oh          = '0;
                    oh[i]       = 1'b1;
                    exp_grant   = last_q[i][0] ? '0 : oh;
                    mid[i]      = !last_q[i][0];
                    void'(byte_q[i].pop_front());
                    void'(last_q[i].pop_front());
                end
            end
        end
        rst_prev = rst_req;
        prev_tdr = tx_data_ready;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input int r, input logic [7:0] b, input bit l);
        byte_q[r].push_back(b);
        last_q[r].push_back(l);
    endtask

    task automatic run_drain(input int limit);
        bit drained;
        drained = 1'b0;
        for (int c = 0; c < limit && !drained; c++) begin
            step();
            drained = (exp_q.size() == 0) && uart_idle() && !tx_data_ready && !acc_prev;
            for (int i = 0; i < N; i++) if (byte_q[i].size() != 0) drained = 1'b0;
        end
        check("drained", drained, 1);
        step();
        step();
        check("idle_busy", busy, 0);
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp [$]);
        check({tag, "_count"}, line_log.size(), exp.size());
        for (int k = 0; k < exp.size() && k < line_log.size(); k++) begin
            check(tag, line_log[k], exp[k]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_done   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        step();
        chk_en = 1'b1;
        step();
        rst_req = 1'b0;

        // Single-byte packet from req0.
        line_log.delete();
        push(0, 8'hA5, 1'b1);
        predict(0);
        run_drain(200);
        check_log("single_byte", '{8'hA5});

        // Locked two-byte packet from req1 while req2 waits (ptr is now 1).
        line_log.delete();
        push(1, 8'h01, 1'b0);
        push(1, 8'h80, 1'b1);
        push(2, 8'h55, 1'b1);
        predict(1);
        run_drain(300);
        check_log("locked_packet", '{8'h01, 8'h80, 8'h55});

        // Fairness: all four continuously valid with single-byte packets.
        do_reset();
        line_log.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
        end
        predict(0);
        run_drain(500);
        check_log("round_robin", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13});

        // Reset while req3 is mid-packet and the transmitter is busy.
        begin
            bit reached;
            do_reset();
            line_log.delete();
            push(3, 8'h31, 1'b0);
            push(3, 8'h32, 1'b0);
            push(3, 8'h33, 1'b1);
            predict(0);
            reached = 1'b0;
            for (int c = 0; c < 100 && !reached; c++) begin
                step();
                reached = (line_log.size() == 1) && !tx_done;
            end
            check("reset_reached_busy", reached, 1);
            check("reset_grant_locked", grant, 4'b1000);
            push(0, 8'h0A, 1'b1);
            do_reset();
            line_log.delete();
            predict(0);
            run_drain(300);
            check_log("after_reset", '{8'h0A, 8'h32, 8'h33});
        end

`ifdef TX_ARB_WATCHDOG_EN
        // Owner req2 abandons its packet; watchdog frees the line.
        begin
            bit seen;
            bit fired;
            int stall_n;
            do_reset();
            line_log.delete();
            grant_chk = 1'b0;
            push(2, 8'h21, 1'b0);
            predict(0);
            seen    = 1'b0;
            fired   = 1'b0;
            stall_n = 0;
            for (int c = 0; c < 200 && !fired; c++) begin
                step();
                if (grant != '0) seen = 1'b1;
                fired = seen && (grant == '0);
                if (grant != '0 && uart_idle() && !tx_data_ready) stall_n++;
            end
            check("wd_fired", fired, 1);
            check("wd_stall_cycles", stall_n, WD + 1);
            check("wd_stall_err", stall_err, 1);
            exp_grant = '0;
            grant_chk = 1'b1;
            mid[2]    = 1'b0;
            exp_q.delete();
            line_log.delete();
            push(0, 8'h0B, 1'b1);
            push(2, 8'h22, 1'b1);
            predict(3);
            run_drain(300);
            check_log("wd_after", '{8'h0B, 8'h22});
            check("wd_stall_err_sticky", stall_err, 1);
        end
`endif

        // Random packets, random transmitter timing, random owner gaps.
        for (int round = 0; round < 8; round++) begin
            do_reset();
            line_log.delete();
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            predict(0);
            run_drain(2000);
        end

`ifndef TX_ARB_WATCHDOG_EN
        check("stall_err_tied_low", stall_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
